alu_imm_iq: RTL

- Issue queue that holds dispatched ALU register-immediate ops until operand A is available.
- Drives the issue side of alu_imm_pipeline: issue_valid/issue_ready handshake, operand-source info and PRF read request.
- Oldest-first select over a compressing queue; the oldest entry is at index 0.
- Sits between dispatch (up to 4 ops/cycle) and one alu_imm_pipeline.

---
 rtl/core_types_pkg.sv | 34 +++
 rtl/alu_imm_iq_pe_lsb.sv | 11 +
 rtl/alu_imm_iq.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/core_types_pkg.sv
// Shared core widths, issue-queue entry layout and the PRF wakeup match helper.
package core_types_pkg;

  localparam int PR_COUNT           = 128;
  localparam int LOG_PR_COUNT       = 7;
  localparam int PRF_BANK_COUNT     = 4;
  localparam int LOG_PRF_BANK_COUNT = 2;
  localparam int LOG_ROB_ENTRIES    = 7;
  localparam int ALU_IMM_IQ_ENTRIES = 8;
  localparam int LOG_PR_UPPER       = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

  typedef struct packed {
    logic                       valid;
    logic [3:0]                 op;
    logic [11:0]                imm12;
    logic [LOG_PR_COUNT-1:0]    A_PR;
    logic                       A_ready;
    logic                       A_is_zero;
    logic [LOG_PR_COUNT-1:0]    dest_PR;
    logic [LOG_ROB_ENTRIES-1:0] ROB_index;
  } alu_imm_iq_entry_t;

  // A PR lives in bank PR[low bits]; the bank's WB bus carries only the upper bits.
  function automatic logic pr_woken(
    input logic [LOG_PR_COUNT-1:0]                      pr,
    input logic [PRF_BANK_COUNT-1:0]                    wb_valid,
    input logic [PRF_BANK_COUNT-1:0][LOG_PR_UPPER-1:0]  wb_upper
  );
    logic [LOG_PRF_BANK_COUNT-1:0] bank;
    bank = pr[LOG_PRF_BANK_COUNT-1:0];
    pr_woken = wb_valid[bank] && (wb_upper[bank] == pr[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT]);
  endfunction

endpackage

// File: rtl/alu_imm_iq_pe_lsb.sv
// Lowest-index one-hot priority encoder, used for issue select and slot allocation.
module pe_lsb #(
  parameter int W = 8
) (
  input  logic [W-1:0] req_i,
  output logic [W-1:0] gnt_o
);

  assign gnt_o = req_i & (~req_i + W'(1));

endmodule

// File: rtl/alu_imm_iq.sv
// Compressing oldest-first issue queue for ALU register-immediate ops.
// ALU_IMM_IQ_WAKEUP_BYPASS_EN: when defined, a same-cycle wakeup makes an entry issuable (forwarded operand).
module alu_imm_iq
  import core_types_pkg::*;
#(
  parameter int ALU_IMM_IQ_ENTRIES = core_types_pkg::ALU_IMM_IQ_ENTRIES,
  parameter int DISPATCH_WAYS      = 4
) (
  input  logic                                            CLK,
  input  logic                                            nRST,
  input  logic [DISPATCH_WAYS-1:0]                        dispatch_attempt_by_way,
  input  logic [DISPATCH_WAYS-1:0]                        dispatch_valid_by_way,
  input  logic [DISPATCH_WAYS-1:0][3:0]                   dispatch_op_by_way,
  input  logic [DISPATCH_WAYS-1:0][11:0]                  dispatch_imm12_by_way,
  input  logic [DISPATCH_WAYS-1:0][LOG_PR_COUNT-1:0]      dispatch_A_PR_by_way,
  input  logic [DISPATCH_WAYS-1:0]                        dispatch_A_ready_by_way,
  input  logic [DISPATCH_WAYS-1:0]                        dispatch_A_is_zero_by_way,
  input  logic [DISPATCH_WAYS-1:0][LOG_PR_COUNT-1:0]      dispatch_dest_PR_by_way,
  input  logic [DISPATCH_WAYS-1:0][LOG_ROB_ENTRIES-1:0]   dispatch_ROB_index_by_way,
  output logic [DISPATCH_WAYS-1:0]                        dispatch_ack_by_way,
  input  logic [PRF_BANK_COUNT-1:0]                       WB_bus_valid_by_bank,
  input  logic [PRF_BANK_COUNT-1:0][LOG_PR_UPPER-1:0]     WB_bus_upper_PR_by_bank,
  output logic                                            issue_valid,
  output logic [3:0]                                      issue_op,
  output logic [11:0]                                     issue_imm12,
  output logic                                            issue_A_forward,
  output logic                                            issue_A_is_zero,
  output logic [LOG_PRF_BANK_COUNT-1:0]                   issue_A_bank,
  output logic [LOG_PR_COUNT-1:0]                         issue_dest_PR,
  output logic [LOG_ROB_ENTRIES-1:0]                      issue_ROB_index,
  input  logic                                            issue_ready,
  output logic                                            PRF_req_A_valid,
  output logic [LOG_PR_COUNT-1:0]                         PRF_req_A_PR
);

  localparam int N  = ALU_IMM_IQ_ENTRIES;
  localparam int IW = $clog2(N);

  alu_imm_iq_entry_t entries_q [N];
  alu_imm_iq_entry_t entries_d [N];
  alu_imm_iq_entry_t shifted   [N];
  alu_imm_iq_entry_t sel;

  logic [N-1:0]                      ready_vec;
  logic [N-1:0]                      sel_oh;
  logic [N-1:0]                      shifted_valid;
  logic [IW-1:0]                     sel_idx;
  logic                              fire;
  logic [DISPATCH_WAYS-1:0]          write_en;
  logic [DISPATCH_WAYS:0][N-1:0]     free_mask;
  logic [DISPATCH_WAYS-1:0][N-1:0]   slot_oh;
  int                                free_slots;
  int                                att_below;

`ifdef ALU_IMM_IQ_WAKEUP_BYPASS_EN
  logic [N-1:0] woken_vec;

  always_comb begin
    woken_vec = '0;
    ready_vec = '0;
    for (int i = 0; i < N; i++) begin
      woken_vec[i] = pr_woken(entries_q[i].A_PR, WB_bus_valid_by_bank, WB_bus_upper_PR_by_bank);
      ready_vec[i] = entries_q[i].valid &&
                     (entries_q[i].A_ready || entries_q[i].A_is_zero || woken_vec[i]);
    end
  end
`else
  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < N; i++) begin
      ready_vec[i] = entries_q[i].valid && (entries_q[i].A_ready || entries_q[i].A_is_zero);
    end
  end
`endif

  pe_lsb #(.W(N)) u_select (
    .req_i (ready_vec),
    .gnt_o (sel_oh)
  );

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_oh[i]) sel_idx = IW'(i);
    end
    sel = entries_q[sel_idx];
  end

  assign issue_valid     = |ready_vec;
  assign issue_op        = issue_valid ? sel.op : '0;
  assign issue_imm12     = issue_valid ? sel.imm12 : '0;
  assign issue_A_is_zero = issue_valid && sel.A_is_zero;
  assign issue_A_bank    = issue_valid ? sel.A_PR[LOG_PRF_BANK_COUNT-1:0] : '0;
  assign issue_dest_PR   = issue_valid ? sel.dest_PR : '0;
  assign issue_ROB_index = issue_valid ? sel.ROB_index : '0;
  assign PRF_req_A_PR    = issue_valid ? sel.A_PR : '0;

`ifdef ALU_IMM_IQ_WAKEUP_BYPASS_EN
  assign issue_A_forward = issue_valid && !sel.A_ready && !sel.A_is_zero && woken_vec[sel_idx];
`else
  assign issue_A_forward = 1'b0;
`endif

  // valid/ready: an op leaves the queue on any cycle where issue_valid && issue_ready.
  assign fire            = issue_valid && issue_ready;
  assign PRF_req_A_valid = fire && !issue_A_forward && !issue_A_is_zero;

  // Free count ignores the slot being issued this cycle, so a full queue never acks.
  always_comb begin
    free_slots          = N;
    att_below           = 0;
    dispatch_ack_by_way = '0;
    for (int i = 0; i < N; i++) begin
      free_slots = free_slots - int'(entries_q[i].valid);
    end
    for (int k = 0; k < DISPATCH_WAYS; k++) begin
      dispatch_ack_by_way[k] = dispatch_attempt_by_way[k] && (att_below < free_slots);
      att_below              = att_below + int'(dispatch_attempt_by_way[k]);
    end
  end

  assign write_en = dispatch_ack_by_way & dispatch_valid_by_way;

  // Compress over the issued slot, then apply wakeups to the surviving entries.
  always_comb begin
    shifted_valid = '0;
    for (int i = 0; i < N; i++) begin
      shifted[i] = entries_q[i];
    end
    for (int i = 0; i < N - 1; i++) begin
      if (fire && (i >= int'(sel_idx))) shifted[i] = entries_q[i+1];
    end
    if (fire) shifted[N-1] = '0;
    for (int i = 0; i < N; i++) begin
      if (shifted[i].valid &&
          pr_woken(shifted[i].A_PR, WB_bus_valid_by_bank, WB_bus_upper_PR_by_bank)) begin
        shifted[i].A_ready = 1'b1;
      end
      shifted_valid[i] = shifted[i].valid;
    end
  end

  assign free_mask[0] = ~shifted_valid;

  for (genvar w = 0; w < DISPATCH_WAYS; w++) begin : g_alloc
    pe_lsb #(.W(N)) u_alloc (
      .req_i (free_mask[w]),
      .gnt_o (slot_oh[w])
    );
    assign free_mask[w+1] = write_en[w] ? (free_mask[w] & ~slot_oh[w]) : free_mask[w];
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      entries_d[i] = shifted[i];
    end
    for (int w = 0; w < DISPATCH_WAYS; w++) begin
      for (int i = 0; i < N; i++) begin
        if (write_en[w] && slot_oh[w][i]) begin
          entries_d[i].valid     = 1'b1;
          entries_d[i].op        = dispatch_op_by_way[w];
          entries_d[i].imm12     = dispatch_imm12_by_way[w];
          entries_d[i].A_PR      = dispatch_A_PR_by_way[w];
          entries_d[i].A_ready   = dispatch_A_ready_by_way[w] ||
                                   pr_woken(dispatch_A_PR_by_way[w], WB_bus_valid_by_bank,
                                            WB_bus_upper_PR_by_bank);
          entries_d[i].A_is_zero = dispatch_A_is_zero_by_way[w];
          entries_d[i].dest_PR   = dispatch_dest_PR_by_way[w];
          entries_d[i].ROB_index = dispatch_ROB_index_by_way[w];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < N; i++) entries_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) entries_q[i] <= entries_d[i];
    end
  end

endmodule
